// File: rtl/cia_serial_bridge_if.sv
// Byte-stream handshake bundle for cia_serial_bridge: RX FIFO head and TX byte acceptance.
// The bridge takes the slave modport; the consumer/producer side takes master.
interface cia_serial_bridge_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/cia_serial_bridge.sv
// CIA SP/CNT byte bridge: captures bytes shifted out by the CIA into an RX FIFO, or serialises
// TX bytes onto the CIA's SP/CNT inputs, all paced by the Phi2 positive-edge enable.
module cia_serial_bridge #(
   parameter int unsigned FIFO_AW  = 2,
   parameter int unsigned HALF_BIT = 4
) (
   input  logic                 clk,
   input  logic                 res_n,
   input  logic                 phi2_p,
   input  logic                 dir,
   input  logic                 cia_sp,
   input  logic                 cia_cnt,
   output logic                 sp_to_cia,
   output logic                 cnt_to_cia,
   cia_serial_bridge_if.slave   bus,
   output logic                 rx_overflow,
   output logic                 busy
);

   localparam int unsigned Depth  = 1 << FIFO_AW;
   localparam logic [7:0]  HalfM1 = 8'(HALF_BIT - 1);

   typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

   logic               dir_q;
   logic               cnt_prev_q, cnt_prev_d;
   logic [6:0]         cap_sr_q, cap_sr_d;
   logic [2:0]         cap_cnt_q, cap_cnt_d;
   logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]         mem_q [Depth];
   logic [7:0]         mem_d [Depth];
   logic               ovf_q, ovf_d;
   state_e             state_q, state_d;
   logic [7:0]         timer_q, timer_d;
   logic [2:0]         bit_q, bit_d;
   logic [6:0]         tx_sr_q, tx_sr_d;
   logic               sp_q, sp_d;
   logic               cnt_q, cnt_d;

   logic               dir_chg;
   logic               cnt_rise;
   logic               fifo_empty;
   logic               fifo_full;
   logic               pop;
   logic               push;
   logic [7:0]         push_byte;

   assign dir_chg    = dir ^ dir_q;
   assign cnt_rise   = phi2_p & ~cnt_prev_q & cia_cnt;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign pop        = ~fifo_empty & bus.rx_ready;
   assign push_byte  = {cap_sr_q, cia_sp};

   // Capture shifter: SP is registered by the CIA on the same edge as CNT, so it is valid here.
   always_comb begin
      cnt_prev_d = phi2_p ? cia_cnt : cnt_prev_q;
      cap_sr_d   = cap_sr_q;
      cap_cnt_d  = cap_cnt_q;
      push       = 1'b0;
      if (dir_chg) begin
         cap_cnt_d = 3'd0;
      end else if (dir && cnt_rise) begin
         cap_sr_d  = push_byte[6:0];
         cap_cnt_d = cap_cnt_q + 3'd1;
         push      = (cap_cnt_q == 3'd7);
      end
   end

   // A pop in the same clk frees the slot, so a full FIFO still accepts the push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      ovf_d    = 1'b0;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
         if (!fifo_full || pop) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = push_byte;
            wr_ptr_d                     = wr_ptr_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      tx_sr_d = tx_sr_q;
      sp_d    = sp_q;
      cnt_d   = cnt_q;
      if (dir_chg) begin
         state_d = StIdle;
         sp_d    = 1'b1;
         cnt_d   = 1'b1;
      end else if (!dir && phi2_p) begin
         unique case (state_q)
            StIdle: begin
               if (bus.tx_valid) begin
                  tx_sr_d = bus.tx_data[6:0];
                  sp_d    = bus.tx_data[7];
                  cnt_d   = 1'b0;
                  timer_d = HalfM1;
                  bit_d   = 3'd0;
                  state_d = StLow;
               end
            end
            StLow: begin
               if (timer_q != 8'd0) begin
                  timer_d = timer_q - 8'd1;
               end else begin
                  cnt_d   = 1'b1;
                  timer_d = HalfM1;
                  state_d = StHigh;
               end
            end
            StHigh: begin
               if (timer_q != 8'd0) begin
                  timer_d = timer_q - 8'd1;
               end else if (bit_q == 3'd7) begin
                  state_d = StIdle;
               end else begin
                  // SP only moves together with the CNT falling edge.
                  bit_d   = bit_q + 3'd1;
                  sp_d    = tx_sr_q[6];
                  tx_sr_d = {tx_sr_q[5:0], 1'b0};
                  cnt_d   = 1'b0;
                  timer_d = HalfM1;
                  state_d = StLow;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         dir_q      <= dir;
         cnt_prev_q <= 1'b1;
         cap_sr_q   <= 7'd0;
         cap_cnt_q  <= 3'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
         state_q    <= StIdle;
         timer_q    <= 8'd0;
         bit_q      <= 3'd0;
         tx_sr_q    <= 7'd0;
         sp_q       <= 1'b1;
         cnt_q      <= 1'b1;
      end else begin
         dir_q      <= dir;
         cnt_prev_q <= cnt_prev_d;
         cap_sr_q   <= cap_sr_d;
         cap_cnt_q  <= cap_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_q      <= bit_d;
         tx_sr_q    <= tx_sr_d;
         sp_q       <= sp_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Holding tx_ready low in the dir-change clk keeps it honest while that clk blocks acceptance.
   assign bus.tx_ready = ~dir & ~dir_q & (state_q == StIdle);
   assign bus.rx_valid = ~fifo_empty;
   assign bus.rx_data  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign sp_to_cia    = sp_q;
   assign cnt_to_cia   = cnt_q;
   assign rx_overflow  = ovf_q;
   assign busy         = (cap_cnt_q != 3'd0) | (state_q != StIdle);

endmodule

// File: tb/tb_cia_serial_bridge.sv
// Directed bench for cia_serial_bridge: a vector table of capture/drive bytes plus hand-written
// overflow, simultaneous push/pop, direction-flip and mid-byte reset sequences.
module tb_cia_serial_bridge;
   localparam int unsigned HB = 4;

   logic clk, res_n, phi2_p, dir, cia_sp, cia_cnt;
   logic sp_to_cia, cnt_to_cia, rx_overflow, busy;
   int   n_vec, n_err, ov_cnt;

   cia_serial_bridge_if bus ();

   cia_serial_bridge #(
      .FIFO_AW  (2),
      .HALF_BIT (HB)
   ) dut (
      .clk         (clk),
      .res_n       (res_n),
      .phi2_p      (phi2_p),
      .dir         (dir),
      .cia_sp      (cia_sp),
      .cia_cnt     (cia_cnt),
      .sp_to_cia   (sp_to_cia),
      .cnt_to_cia  (cnt_to_cia),
      .bus         (bus),
      .rx_overflow (rx_overflow),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial ov_cnt = 0;
   always @(negedge clk) if (rx_overflow !== 1'b0) ov_cnt++;

   typedef struct {
      logic       dir;
      logic [7:0] bits;
      logic [7:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      phi2_p = 1'b1;
      @(posedge clk); #1;
      phi2_p = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic cap_bit(input logic b, input logic pop_at_push);
      cia_sp  = b;
      cia_cnt = 1'b0;
      tick();
      cia_cnt      = 1'b1;
      phi2_p       = 1'b1;
      bus.rx_ready = pop_at_push;
      @(posedge clk); #1;
      bus.rx_ready = 1'b0;
      phi2_p       = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic cap_byte(input logic [7:0] d, input logic pop_last);
      for (int i = 7; i >= 0; i--) cap_bit(d[i], pop_last && (i == 0));
   endtask

   task automatic pop_expect(input string name, input logic [7:0] d);
      check({name, " valid"}, {31'd0, bus.rx_valid}, 32'd1);
      check({name, " data"}, {24'd0, bus.rx_data}, {24'd0, d});
      bus.rx_ready = 1'b1;
      @(posedge clk); #1;
      bus.rx_ready = 1'b0;
   endtask

   task automatic set_dir(input logic v);
      dir = v;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   // Acts as the receiving CIA: shifts SP on every CNT rise and times the bit cells.
   task automatic drive_byte(input logic [7:0] d);
      logic [7:0] sdr;
      logic       prev_cnt;
      int         rises, low, last_rise, bad_gap, t;
      sdr = 8'd0; rises = 0; low = 0; last_rise = 0; bad_gap = 0; t = 0;
      check("drv tx_ready idle", {31'd0, bus.tx_ready}, 32'd1);
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      check("drv first sp", {31'd0, sp_to_cia}, {31'd0, d[7]});
      check("drv first cnt", {31'd0, cnt_to_cia}, 32'd0);
      check("drv busy", {31'd0, busy}, 32'd1);
      prev_cnt = cnt_to_cia;
      if (!bus.tx_ready) low = 1;
      while (t < 400) begin
         tick();
         t++;
         if (!prev_cnt && cnt_to_cia) begin
            sdr = {sdr[6:0], sp_to_cia};
            if (rises == 0 && t != int'(HB)) bad_gap++;
            if (rises > 0 && (t - last_rise) != int'(2 * HB)) bad_gap++;
            last_rise = t;
            rises++;
         end
         prev_cnt = cnt_to_cia;
         if (bus.tx_ready) break;
         low++;
      end
      check("drv cnt rises", rises, 8);
      check("drv rise spacing errors", bad_gap, 0);
      check("drv sdr", {24'd0, sdr}, {24'd0, d});
      check("drv tx_ready low periods", low, int'(16 * HB));
      check("drv idle sp holds last bit", {31'd0, sp_to_cia}, {31'd0, d[0]});
      check("drv idle cnt", {31'd0, cnt_to_cia}, 32'd1);
      check("drv idle busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [6];
      int   ov_base, rises, t;
      logic prev_cnt;

      vecs[0] = '{dir: 1'b1, bits: 8'b1010_0101, exp: 8'hA5};
      vecs[1] = '{dir: 1'b1, bits: 8'b0011_1100, exp: 8'h3C};
      vecs[2] = '{dir: 1'b1, bits: 8'b0000_0000, exp: 8'h00};
      vecs[3] = '{dir: 1'b0, bits: 8'b0011_1100, exp: 8'h3C};
      vecs[4] = '{dir: 1'b0, bits: 8'b1010_0101, exp: 8'hA5};
      vecs[5] = '{dir: 1'b0, bits: 8'b1111_1111, exp: 8'hFF};

      n_vec = 0; n_err = 0;
      res_n = 1'b0; dir = 1'b0; phi2_p = 1'b0; cia_sp = 1'b1; cia_cnt = 1'b1;
      bus.rx_ready = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst sp", {31'd0, sp_to_cia}, 32'd1);
      check("rst cnt", {31'd0, cnt_to_cia}, 32'd1);
      check("rst rx_valid", {31'd0, bus.rx_valid}, 32'd0);
      check("rst tx_ready", {31'd0, bus.tx_ready}, 32'd1);
      check("rst overflow", {31'd0, rx_overflow}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      res_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         if (dir != vecs[i].dir) set_dir(vecs[i].dir);
         if (vecs[i].dir) begin
            cap_byte(vecs[i].bits, 1'b0);
            check("cap busy after byte", {31'd0, busy}, 32'd0);
            pop_expect("cap pop", vecs[i].exp);
            check("cap empty after pop", {31'd0, bus.rx_valid}, 32'd0);
         end else begin
            drive_byte(vecs[i].exp);
         end
      end

      // Overflow: fifth byte into a four-deep FIFO is dropped with a single-clk pulse.
      set_dir(1'b1);
      ov_base = ov_cnt;
      for (int b = 1; b <= 4; b++) cap_byte(8'(b), 1'b0);
      check("ovf none while filling", ov_cnt - ov_base, 0);
      cap_byte(8'h05, 1'b0);
      check("ovf single pulse", ov_cnt - ov_base, 1);
      for (int b = 1; b <= 4; b++) pop_expect("ovf pop", 8'(b));
      check("ovf drained", {31'd0, bus.rx_valid}, 32'd0);

      // Full FIFO with a pop in the push clk: nothing is lost.
      for (int b = 1; b <= 4; b++) cap_byte(8'(b), 1'b0);
      check("full head", {24'd0, bus.rx_data}, 32'h01);
      ov_base = ov_cnt;
      cap_byte(8'h05, 1'b1);
      check("full+pop no overflow", ov_cnt - ov_base, 0);
      for (int b = 2; b <= 5; b++) pop_expect("full+pop order", 8'(b));
      check("full+pop drained", {31'd0, bus.rx_valid}, 32'd0);

      // Direction flip after three driven bits.
      set_dir(1'b0);
      bus.tx_data = 8'hFF; bus.tx_valid = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      rises = 0; t = 0; prev_cnt = cnt_to_cia;
      while (rises < 3 && t < 200) begin
         tick();
         t++;
         if (!prev_cnt && cnt_to_cia) rises++;
         prev_cnt = cnt_to_cia;
      end
      check("flip reached 3 bits", rises, 3);
      dir = 1'b1;
      @(posedge clk); #1;
      check("flip cnt", {31'd0, cnt_to_cia}, 32'd1);
      check("flip sp", {31'd0, sp_to_cia}, 32'd1);
      check("flip busy", {31'd0, busy}, 32'd0);
      check("flip tx_ready", {31'd0, bus.tx_ready}, 32'd0);
      set_dir(1'b0);
      drive_byte(8'h81);

      // Reset in the middle of a capture discards the partial byte.
      set_dir(1'b1);
      cap_bit(1'b1, 1'b0); cap_bit(1'b0, 1'b0); cap_bit(1'b1, 1'b0);
      cap_bit(1'b1, 1'b0); cap_bit(1'b0, 1'b0);
      check("midcap busy", {31'd0, busy}, 32'd1);
      ov_base = ov_cnt;
      res_n = 1'b0;
      @(posedge clk); #1;
      check("midrst sp", {31'd0, sp_to_cia}, 32'd1);
      check("midrst cnt", {31'd0, cnt_to_cia}, 32'd1);
      check("midrst rx_valid", {31'd0, bus.rx_valid}, 32'd0);
      check("midrst tx_ready", {31'd0, bus.tx_ready}, 32'd0);
      check("midrst overflow", {31'd0, rx_overflow}, 32'd0);
      check("midrst busy", {31'd0, busy}, 32'd0);
      res_n = 1'b1;
      @(posedge clk); #1;
      cap_byte(8'h7E, 1'b0);
      pop_expect("post-rst capture", 8'h7E);
      check("post-rst single byte", {31'd0, bus.rx_valid}, 32'd0);
      check("post-rst no overflow", ov_cnt - ov_base, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cia_serial_bridge.md
# cia_serial_bridge

Byte-level bridge on the CIA serial port (SP/CNT) used for the C128 fast-serial link. In capture mode it deserialises bytes the CIA shifts out (CIA CRA[6]=1) into a small RX FIFO. In drive mode it serialises bytes from a TX handshake into the CIA's SP/CNT inputs (CIA CRA[6]=0). All serial-side activity is paced by the Phi2 positive-edge enable, matching the CIA's own sampling.

## Interface
- FIFO_AW, 2: RX FIFO address width; depth = 2^FIFO_AW bytes.
- HALF_BIT, 4: Phi2 cycles per CNT half-period when driving; legal range 1..255.

- clk  in  1  system clock
- res_n  in  1  synchronous active-low reset, sampled on posedge clk
- phi2_p  in  1  one-clk Phi2 positive-edge enable
- dir  in  1  1 = capture (CIA transmits), 0 = drive (CIA receives)
- cia_sp  in  1  CIA sp_out
- cia_cnt  in  1  CIA cnt_out
- sp_to_cia  out  1  data to CIA sp_in
- cnt_to_cia  out  1  clock to CIA cnt_in
- rx_data  out  8  head of RX FIFO
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  consumer pops head when rx_valid & rx_ready (any clk)
- tx_data  in  8  byte to send
- tx_valid  in  1  byte available
- tx_ready  out  1  bridge can accept a byte
- rx_overflow  out  1  one-clk pulse: completed byte dropped
- busy  out  1  capture byte partially received or drive FSM not IDLE

## Operation
- Reset values: sp_to_cia=1, cnt_to_cia=1, rx_valid=0, rx_data=don't-care, tx_ready=~dir, rx_overflow=0, busy=0. FIFO empty, bit counters 0, FSM IDLE, cnt_prev=1.
- cnt_prev updates to cia_cnt on every phi2_p.
- Capture (dir=1). On phi2_p with cnt_prev=0 and cia_cnt=1, shift cia_sp into an 8-bit register MSB-first and increment a 3-bit count.
  - The CIA registers SP and CNT on the same edge, so SP is valid at detection.
  - When count wraps 7→0, push the byte in the same clk.
- Push rule: the push succeeds if the FIFO is not full, or if a pop occurs in the same clk. Otherwise the byte is dropped and rx_overflow pulses.
- Pop rule: pops happen on any clk. Pointers wrap modulo 2^FIFO_AW, with an extra MSB for full/empty distinction.
- Drive (dir=0) FSM has three states: IDLE, LOW, HIGH. Timer is 8-bit; bit index is 3-bit.
  - IDLE: tx_ready=1. On phi2_p & tx_valid, latch tx_data. Then sp_to_cia=tx_data[7], cnt_to_cia=0, timer=HALF_BIT-1, go to LOW.
  - LOW: on phi2_p, if timer≠0 decrement. Else cnt_to_cia=1, timer=HALF_BIT-1, go to HIGH.
  - HIGH: on phi2_p, if timer≠0 decrement. Else:
    - if the last bit has been sent, go to IDLE;
    - otherwise put the next bit (MSB-first) on sp_to_cia, set cnt_to_cia=0, go to LOW.
  - sp_to_cia holds the last bit in IDLE until the next byte.
- Direction change: any dir transition (detected per clk) immediately does the following:
  - FSM→IDLE, cnt_to_cia=1, sp_to_cia=1;
  - capture count cleared; the partial byte is discarded.
  - FIFO contents are preserved.
  - In capture mode tx_ready=0 and cnt_to_cia/sp_to_cia are held at 1.
- busy = (capture count≠0) | (FSM≠IDLE).

## Timing
- Capture: rx_valid rises 1 clk after the phi2_p that samples the 8th rising CNT edge; rx_data is valid in that same cycle.
- Drive: tx_valid & tx_ready on a phi2_p clk = acceptance. tx_ready falls the next clk.
- Per-bit CNT: low for HALF_BIT phi2_p periods, then high for HALF_BIT. Total 16·HALF_BIT phi2_p periods per byte.
- SP changes only together with the CNT falling edge. SP is stable for HALF_BIT periods before each rising edge.
- tx_ready returns 1 in the clk after the final HIGH period expires. Back-to-back bytes therefore have no extra gap beyond that acceptance phi2_p.
- Reset mid-byte: all state returns to reset values in 1 clk. A partial byte is neither pushed nor resumed.

## Test plan
- Capture 0xA5 (dir=1): 8 CNT low/high pulses with SP=1,0,1,0,0,1,0,1 → rx_valid=1, rx_data=0xA5; pop → rx_valid=0.
- Overflow (FIFO_AW=2, rx_ready=0): capture 0x01..0x05 → 5th byte raises rx_overflow for 1 clk; pops return 0x01..0x04.
- Full + simultaneous pop: FIFO full, rx_ready=1 in the push clk → no overflow; order 0x02,0x03,0x04,0x05.
- Drive 0x3C, HALF_BIT=4: check 8 CNT rising edges, 8 phi2_p apart, with SP=0,0,1,1,1,1,0,0 at each rise. tx_ready is low for 64 phi2_p, and an attached CIA (CRA[6]=0) reads SDR=0x3C.
- Dir flip mid-drive after 3 bits: next clk gives cnt_to_cia=1, sp_to_cia=1, busy=0, tx_ready=0. Then dir back to 0 → a new 0x81 is sent intact.
- Reset asserted mid-capture after 5 bits: all outputs at reset values. A following full 0x7E capture yields exactly one byte 0x7E.
